// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: time-multiplexed 7-segment scan with blanking gaps, leading-zero suppression and frame-aligned loads
module display_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                      iClk,
  input  logic                      iReset_n,
  input  logic [4*NUM_DIGITS-1:0]   iValue,
  input  logic                      iLoad,
  output logic                      oLoadAck,
  input  logic                      iBlankLZ,
  output logic [3:0]                oDigit,
  output logic [NUM_DIGITS-1:0]     oDigitSel,
  output logic                      oFrameStart
);
  localparam int KW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  logic [KW-1:0] k, k_n;
  logic [IW-1:0] idx, idx_n;
  logic [NUM_DIGITS-1:0][3:0] sh, sh_n;
  logic [NUM_DIGITS:0] za;
  logic cap, blank, sup;
  // next slot position, frame-boundary capture and per-digit blanking decisions
  always_comb begin
    k_n = (k == KW'(SCAN_DIV - 1)) ? '0 : k + 1'b1;
    idx_n = (k != KW'(SCAN_DIV - 1)) ? idx : (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    cap = iLoad && k_n == '0 && idx_n == '0;
    sh_n = cap ? iValue : sh;
    za[NUM_DIGITS] = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) za[i] = za[i+1] && sh_n[i] == 4'd0;
    blank = BLANK_CYCLES > 0 && int'(k_n) < BLANK_CYCLES;
    sup = iBlankLZ && idx_n != '0 && za[idx_n];
  end
  // scan position, shadow value and registered outputs; reset parks at the last cycle of the frame
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      k <= KW'(SCAN_DIV - 1);
      idx <= IW'(NUM_DIGITS - 1);
      sh <= '0;
      oLoadAck <= 1'b0;
      oFrameStart <= 1'b0;
      oDigitSel <= '1;
      oDigit <= 4'd0;
    end else begin
      k <= k_n;
      idx <= idx_n;
      sh <= sh_n;
      oLoadAck <= cap;
      oFrameStart <= k_n == '0 && idx_n == '0;
      oDigitSel <= (blank || sup) ? '1 : ~(NUM_DIGITS'(1) << idx_n);
      oDigit <= (blank || sup) ? 4'd0 : sh_n[idx_n];
    end
  end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: directed checks plus a cycle model for two blanking configurations
module tb_display_scan_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, load = 1'b0, blz = 1'b0;
  logic [15:0] val = 16'h0;
  logic a_ack, a_fs, b_ack, b_fs;
  logic [3:0] a_digit, a_sel, b_digit, b_sel;
  int checks = 0, failures = 0, c = 0;
  bit started = 1'b0, m_ack = 1'b0, m_lz = 1'b0;
  logic [15:0] m_sh = 16'h0;

  display_scan_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYCLES(2)) dut_a (
    .iClk(clk), .iReset_n(rst_n), .iValue(val), .iLoad(load), .oLoadAck(a_ack),
    .iBlankLZ(blz), .oDigit(a_digit), .oDigitSel(a_sel), .oFrameStart(a_fs));
  display_scan_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYCLES(0)) dut_b (
    .iClk(clk), .iReset_n(rst_n), .iValue(val), .iLoad(load), .oLoadAck(b_ack),
    .iBlankLZ(blz), .oDigit(b_digit), .oDigitSel(b_sel), .oFrameStart(b_fs));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at c=%0d actual=%0h required=%0h", name, c, act, exp);
    end
  endtask

  function automatic bit suppressed(int cc, int blank, logic [15:0] sh, bit lz);
    int k = cc % 8, i = (cc / 8) % 4;
    return k < blank || (lz && i > 0 && (sh >> (4 * i)) == 16'h0);
  endfunction

  function automatic logic [3:0] e_sel(int cc, int blank, logic [15:0] sh, bit lz);
    logic [3:0] one = 4'b0001;
    return suppressed(cc, blank, sh, lz) ? 4'hF : ~(one << ((cc / 8) % 4));
  endfunction

  function automatic logic [3:0] e_dig(int cc, int blank, logic [15:0] sh, bit lz);
    logic [15:0] s = sh >> (4 * ((cc / 8) % 4));
    return suppressed(cc, blank, sh, lz) ? 4'h0 : s[3:0];
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      started = 1'b0;
      m_sh = 16'h0;
      m_ack = 1'b0;
    end else begin
      c = started ? c + 1 : 0;
      started = 1'b1;
      m_lz = blz;
      m_ack = (c % 32 == 0) && load;
      if (m_ack) m_sh = val;
    end
    #1;
    if (started) begin
      chk("a_sel", a_sel, e_sel(c, 2, m_sh, m_lz));
      chk("a_digit", a_digit, e_dig(c, 2, m_sh, m_lz));
      chk("a_ack", a_ack, m_ack);
      chk("a_fs", a_fs, c % 32 == 0);
      chk("b_sel", b_sel, e_sel(c, 0, m_sh, m_lz));
      chk("b_digit", b_digit, e_dig(c, 0, m_sh, m_lz));
      chk("b_ack", b_ack, m_ack);
      chk("b_fs", b_fs, c % 32 == 0);
    end else begin
      chk("rst_sel", {a_sel, b_sel}, 8'hFF);
      chk("rst_out", {a_digit, b_digit, a_ack, b_ack, a_fs, b_fs}, 12'h0);
    end
  end

  task automatic step_to(input int n);
    int g = 0;
    do begin
      @(posedge clk);
      #2;
      g++;
    end while (!(started && c == n) && g < 1000);
    if (g >= 1000) begin
      checks++;
      failures++;
      $display("FAIL step_to timeout actual=%0d required=%0d", c, n);
    end
  endtask

  initial begin
    #7;
    chk("init_sel", a_sel, 4'hF);
    chk("init_out", {a_digit, a_ack, a_fs}, 6'h0);
    #10 rst_n = 1'b1;
    step_to(0);
    chk("c0_fs", a_fs, 1'b1);
    chk("c0_sel", a_sel, 4'hF);
    chk("c0_bsel", b_sel, 4'hE);
    step_to(2);  chk("c2_sel", a_sel, 4'hE);
    step_to(4);  val = 16'h1234; load = 1'b1;
    step_to(8);  chk("c8_sel", a_sel, 4'hF);
    step_to(10); chk("c10_sel", a_sel, 4'hD);
    step_to(26); chk("c26_sel", a_sel, 4'h7);
    step_to(31); chk("c31_ack", a_ack, 1'b0);
    step_to(32); chk("c32_ack", a_ack, 1'b1); chk("c32_b", {b_sel, b_digit}, 8'hE4); load = 1'b0;
    step_to(33); chk("c33_ack", a_ack, 1'b0);
    step_to(34); chk("c34", {a_sel, a_digit}, 8'hE4);
    step_to(42); chk("c42", {a_sel, a_digit}, 8'hD3);
    step_to(58); chk("c58", {a_sel, a_digit}, 8'h71);
    step_to(63); val = 16'hBEEF; load = 1'b1;
    step_to(64); chk("c64_ack", a_ack, 1'b1); load = 1'b0;
    step_to(65); val = 16'h0050; load = 1'b1;
    step_to(66); chk("c66", {a_sel, a_digit}, 8'hEF);
    step_to(90); chk("c90", {a_sel, a_digit}, 8'h7B);
    step_to(96); chk("c96_ack", a_ack, 1'b1); load = 1'b0; blz = 1'b1;
    step_to(98); chk("c98", {a_sel, a_digit}, 8'hE0);
    step_to(100); val = 16'h0000; load = 1'b1;
    step_to(106); chk("c106", {a_sel, a_digit}, 8'hD5);
    step_to(114); chk("c114", {a_sel, a_digit}, 8'hF0);
    step_to(122); chk("c122", {a_sel, a_digit}, 8'hF0);
    step_to(128); chk("c128_ack", a_ack, 1'b1); load = 1'b0;
    step_to(130); chk("c130", {a_sel, a_digit}, 8'hE0);
    step_to(138); chk("c138", {a_sel, a_digit}, 8'hF0);
    step_to(140); blz = 1'b0;
    step_to(146); chk("c146", {a_sel, a_digit}, 8'hB0);
    step_to(154); chk("c154", {a_sel, a_digit}, 8'h70);
    step_to(160); val = 16'hABCD; load = 1'b1;
    step_to(173);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_sel", {a_sel, b_sel}, 8'hFF);
    chk("midrst_out", {a_digit, b_digit, a_ack, b_ack, a_fs, b_fs}, 12'h0);
    load = 1'b0;
    blz = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b1;
    step_to(0);  chk("rel_fs", a_fs, 1'b1); chk("rel_ack", a_ack, 1'b0);
    step_to(2);  chk("rel_c2", {a_sel, a_digit}, 8'hE0);
    step_to(10); chk("rel_c10", a_sel, 4'hF);
    step_to(40);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=done", c);
    $fatal(1, "timeout");
  end
endmodule
